// File: rtl/cam_init_pkg.sv
// Shared definitions for the camera register-initialisation sequencer.
// Holds the FSM state encoding, the marker addresses and the table-entry field accessors.
// Entry layout: {reg_addr[15:0], reg_data[7:0]}.
package cam_init_pkg;

  localparam int ENTRY_W = 24;

  // Table entries whose reg_addr is one of these markers are not written to the sensor.
  localparam logic [15:0] DELAY_ADDR = 16'hFFFF;
  localparam logic [15:0] END_ADDR   = 16'hFFFE;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_LATCH    = 4'd2,
    ST_ISSUE    = 4'd3,
    ST_WAIT_ACK = 4'd4,
    ST_DELAY    = 4'd5,
    ST_NEXT     = 4'd6,
    ST_DONE     = 4'd7,
    ST_ERROR    = 4'd8
  } state_t;

  function automatic logic [15:0] entry_addr(input logic [ENTRY_W-1:0] e);
    return e[23:8];
  endfunction

  function automatic logic [7:0] entry_data(input logic [ENTRY_W-1:0] e);
    return e[7:0];
  endfunction

endpackage

// File: rtl/cam_init_lut.sv
// Sensor register table: registered ROM, lut_data valid one clk after lut_index.
// Ports: clk, reset (async, active-high), lut_index in, lut_data {reg_addr, reg_data} out.
// Indices past the populated entries read as an END marker so the walk stops early.
module cam_init_lut
  import cam_init_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         lut_index,
  output logic [ENTRY_W-1:0] lut_data
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lut_data <= '0;
    end else begin
      case (lut_index)
        8'd0:    lut_data <= {16'h3008, 8'h82};   // software reset
        8'd1:    lut_data <= {DELAY_ADDR, 8'h05}; // let the sensor settle after reset
        8'd2:    lut_data <= {16'h3008, 8'h42};   // power down while configuring
        8'd3:    lut_data <= {16'h3103, 8'h03};   // PLL clock source
        8'd4:    lut_data <= {16'h3017, 8'hFF};   // pad output enables
        8'd5:    lut_data <= {16'h3018, 8'hFF};
        8'd6:    lut_data <= {16'h4300, 8'h61};   // RGB565 output format
        8'd7:    lut_data <= {16'h501F, 8'h01};
        8'd8:    lut_data <= {16'h3008, 8'h02};   // wake up
        default: lut_data <= {END_ADDR, 8'h00};
      endcase
    end
  end

endmodule

// File: rtl/cam_init_seq.sv
// Camera register-init sequencer: walks the table, one SCCB write per entry, with delays and retry.
// Ports: clk/reset; initial_en arm level; lut_index/lut_data table port; sccb_req/addr/wdata/ack/nack
// write handshake; busy, init_done, init_err status. All outputs registered.
module cam_init_seq
  import cam_init_pkg::*;
#(
  parameter logic [7:0]  LUT_SIZE     = 8'd200,
  parameter logic [1:0]  MAX_RETRY    = 2'd3,
  parameter logic [19:0] DELAY_CYCLES = 20'd24000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               initial_en,
  output logic [7:0]         lut_index,
  input  logic [ENTRY_W-1:0] lut_data,
  output logic               sccb_req,
  output logic [15:0]        sccb_addr,
  output logic [7:0]         sccb_wdata,
  input  logic               sccb_ack,
  input  logic               sccb_nack,
  output logic               busy,
  output logic               init_done,
  output logic               init_err
);

  state_t      state;
  logic [1:0]  retry;
  logic [19:0] cyc_cnt;
  logic [7:0]  unit_cnt;
  logic        abort;   // initial_en dropped while a bus write was in flight

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      lut_index  <= '0;
      sccb_req   <= 1'b0;
      sccb_addr  <= '0;
      sccb_wdata <= '0;
      busy       <= 1'b0;
      init_done  <= 1'b0;
      init_err   <= 1'b0;
      retry      <= '0;
      cyc_cnt    <= '0;
      unit_cnt   <= '0;
      abort      <= 1'b0;
    end else if (!initial_en &&
                 (state inside {ST_FETCH, ST_LATCH, ST_ISSUE, ST_DELAY, ST_NEXT})) begin
      // No bus transaction is open in these states, so the walk can be dropped at once.
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          abort <= 1'b0;
          if (initial_en) begin
            state     <= ST_FETCH;
            lut_index <= '0;
            retry     <= '0;
            busy      <= 1'b1;
          end
        end

        // ROM is registered: lut_data for the current index is valid in LATCH.
        ST_FETCH: state <= ST_LATCH;

        ST_LATCH: begin
          if (entry_addr(lut_data) == END_ADDR) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else if (entry_addr(lut_data) == DELAY_ADDR) begin
            unit_cnt <= entry_data(lut_data);
            cyc_cnt  <= '0;
            state    <= (entry_data(lut_data) == 8'd0) ? ST_NEXT : ST_DELAY;
          end else begin
            sccb_addr  <= entry_addr(lut_data);
            sccb_wdata <= entry_data(lut_data);
            state      <= ST_ISSUE;
          end
        end

        // Entered from LATCH or after a NACK; req is low here, which guarantees the idle
        // clk between consecutive requests.
        ST_ISSUE: begin
          sccb_req <= 1'b1;
          state    <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (sccb_nack) begin  // nack has priority over a simultaneous ack
            sccb_req <= 1'b0;
            if (abort || !initial_en) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else if (retry < MAX_RETRY) begin
              retry <= retry + 2'd1;
              state <= ST_ISSUE;
            end else begin
              state    <= ST_ERROR;
              busy     <= 1'b0;
              init_err <= 1'b1;
            end
          end else if (sccb_ack) begin
            sccb_req <= 1'b0;
            if (abort || !initial_en) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end else begin
              state <= ST_NEXT;
            end
          end else if (!initial_en) begin
            abort <= 1'b1;
          end
        end

        // unit_cnt is non-zero on entry; each unit is DELAY_CYCLES clks.
        ST_DELAY: begin
          if (cyc_cnt == DELAY_CYCLES - 20'd1) begin
            cyc_cnt  <= '0;
            unit_cnt <= unit_cnt - 8'd1;
            if (unit_cnt == 8'd1) state <= ST_NEXT;
          end else begin
            cyc_cnt <= cyc_cnt + 20'd1;
          end
        end

        ST_NEXT: begin
          retry <= '0;
          if (lut_index == LUT_SIZE - 8'd1) begin
            state     <= ST_DONE;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end else begin
            lut_index <= lut_index + 8'd1;
            state     <= ST_FETCH;
          end
        end

        ST_DONE: begin
          if (!initial_en) begin
            state     <= ST_IDLE;
            init_done <= 1'b0;
          end
        end

        ST_ERROR: begin
          if (!initial_en) begin
            state    <= ST_IDLE;
            init_err <= 1'b0;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
